bsg_link_credit_sender: RTL and testbench

BSG_LINK_CREDIT_SENDER -- requirements
Module: bsg_link_credit_sender

---
 rtl/bsg_link_pkg.sv | 19 +
 rtl/bsg_link_token_sync.sv | 27 ++
 rtl/bsg_link_credit_sender.sv | 127 ++++++++++++
 tb/tb_bsg_link_credit_sender.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_link_pkg.sv
// Shared types for the link credit sender: FSM state encoding and credit width helper.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package bsg_link_pkg;

  // Sender control states; eError is terminal until reset.
  typedef enum logic [1:0] {
    eInit  = 2'd0,
    eRun   = 2'd1,
    eError = 2'd2
  } link_state_e;

  // Width that holds credit_max plus one full token return, so the
  // overflow check sees the true sum before any truncation.
  function automatic int credit_calc_width(input int credit_max, input int decimation);
    return $clog2(credit_max + decimation + 1);
  endfunction

endpackage

// File: rtl/bsg_link_token_sync.sv
// Two-flop synchronizer bringing the receiver's token toggle into core_clk_i.
// Latency: 2 cycles from a stable input to q_o.
// Backpressure: none; samples every cycle.
module bsg_link_token_sync (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic sync1_r;
  logic sync2_r;

  // Two back-to-back flops; both clear on reset so the history flop starts consistent.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= d_i;
      sync2_r <= sync1_r;
    end
  end

  assign q_o = sync2_r;

endmodule

// File: rtl/bsg_link_credit_sender.sv
// Credit-based sender: forwards core words to the link while credits remain, refilled by token toggles.
// Latency: 1 cycle from accepted core word to link_valid_o/link_data_o.
// Backpressure: core_ready_o drops at zero credits, in init and in error; link side has none.
module bsg_link_credit_sender
  import bsg_link_pkg::*;
#(
  parameter int width_p       = 64,
  parameter int credit_max_p  = 32,
  parameter int decimation_p  = 4,
  parameter int init_cycles_p = 4
) (
  input  logic                                core_clk_i,
  input  logic                                core_link_reset_i,
  input  logic [width_p-1:0]                  core_data_i,
  input  logic                                core_valid_i,
  output logic                                core_ready_o,
  input  logic                                token_i,
  output logic [width_p-1:0]                  link_data_o,
  output logic                                link_valid_o,
  output logic [$clog2(credit_max_p+1)-1:0]   credits_o,
  output logic                                credit_error_o
);

  localparam int cw_lp  = $clog2(credit_max_p + 1);
  localparam int ciw_lp = credit_calc_width(credit_max_p, decimation_p);
  localparam int icw_lp = (init_cycles_p > 1) ? $clog2(init_cycles_p) : 1;

  localparam logic [cw_lp-1:0]  credit_reset_lp = cw_lp'(credit_max_p);
  localparam logic [ciw_lp-1:0] credit_max_w_lp = ciw_lp'(credit_max_p);
  localparam logic [ciw_lp-1:0] decimation_w_lp = ciw_lp'(decimation_p);
  localparam logic [icw_lp-1:0] init_reset_lp   = icw_lp'(init_cycles_p - 1);

  link_state_e       state_r, state_n;
  logic [icw_lp-1:0] init_cnt_r, init_cnt_n;
  logic [cw_lp-1:0]  credits_r, credits_n;
  logic              error_r, error_n;
  logic              hist_r;
  logic              tok_sync;
  logic              tok_edge;
  logic              xfer;
  logic [ciw_lp-1:0] credit_sum;

  bsg_link_token_sync u_token_sync (
    .clk_i   (core_clk_i),
    .reset_i (core_link_reset_i),
    .d_i     (token_i),
    .q_o     (tok_sync)
  );

  // History follows the synchronized token every cycle, so edges seen in
  // eInit or eError are consumed without ever reaching the credit count.
  always_ff @(posedge core_clk_i or posedge core_link_reset_i) begin
    if (core_link_reset_i) hist_r <= 1'b0;
    else                   hist_r <= tok_sync;
  end

  assign tok_edge = tok_sync ^ hist_r;
  assign xfer     = core_valid_i & core_ready_o;

  // State register: FSM, init down-counter, credit count and sticky error.
  always_ff @(posedge core_clk_i or posedge core_link_reset_i) begin
    if (core_link_reset_i) begin
      state_r    <= eInit;
      init_cnt_r <= init_reset_lp;
      credits_r  <= credit_reset_lp;
      error_r    <= 1'b0;
    end else begin
      state_r    <= state_n;
      init_cnt_r <= init_cnt_n;
      credits_r  <= credits_n;
      error_r    <= error_n;
    end
  end

  // Next-state: init countdown, credit update in eRun with saturation into eError.
  always_comb begin
    state_n    = state_r;
    init_cnt_n = init_cnt_r;
    credits_n  = credits_r;
    error_n    = error_r;
    // xfer implies credits_r != 0, so the subtraction never wraps.
    credit_sum = ciw_lp'(credits_r)
               + (((state_r == eRun) && tok_edge) ? decimation_w_lp : '0)
               - ciw_lp'(xfer);
    case (state_r)
      eInit: begin
        if (init_cnt_r == '0) state_n = eRun;
        else                  init_cnt_n = init_cnt_r - 1'b1;
      end
      eRun: begin
        if (credit_sum > credit_max_w_lp) begin
          credits_n = credit_reset_lp;
          error_n   = 1'b1;
          state_n   = eError;
        end else begin
          credits_n = cw_lp'(credit_sum);
        end
      end
      eError: begin
        state_n = eError;
      end
      default: begin
        state_n = eError;
        error_n = 1'b1;
      end
    endcase
  end

  // Outputs: ready derives from registered state only, never from this cycle's token.
  always_comb begin
    core_ready_o   = (state_r == eRun) && (credits_r != '0);
    credits_o      = credits_r;
    credit_error_o = error_r;
  end

  // Link register: capture accepted word, pulse valid for one cycle, hold data otherwise.
  always_ff @(posedge core_clk_i or posedge core_link_reset_i) begin
    if (core_link_reset_i) begin
      link_valid_o <= 1'b0;
      link_data_o  <= '0;
    end else begin
      link_valid_o <= xfer;
      if (xfer) link_data_o <= core_data_i;
    end
  end

endmodule

// File: tb/tb_bsg_link_credit_sender.sv
module tb_bsg_link_credit_sender;

  localparam int W  = 64;
  localparam int CM = 32;
  localparam int CW = $clog2(CM + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  data;
  logic          valid;
  logic          ready;
  logic          tok;
  logic [W-1:0]  ldata;
  logic          lv;
  logic [CW-1:0] credits;
  logic          err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        v;
    logic        t;
    logic [63:0] d;
    logic        r;
    logic        lv;
    logic [63:0] ld;
    int          cr;
  } vec_t;

  vec_t tbl[10];

  always #5 clk = ~clk;

  bsg_link_credit_sender #(
    .width_p      (W),
    .credit_max_p (CM),
    .decimation_p (4),
    .init_cycles_p(4)
  ) dut (
    .core_clk_i       (clk),
    .core_link_reset_i(rst),
    .core_data_i      (data),
    .core_valid_i     (valid),
    .core_ready_o     (ready),
    .token_i          (tok),
    .link_data_o      (ldata),
    .link_valid_o     (lv),
    .credits_o        (credits),
    .credit_error_o   (err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at cycle 0: reset just released, next edge is the first.
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int cnt;
    int first;

    rst   = 1'b1;
    valid = 1'b0;
    data  = '0;
    tok   = 1'b0;

    //            v  t  d         r  lv ld        cr
    tbl[0] = '{v:1, t:1, d:64'hA0, r:0, lv:0, ld:64'h0,  cr:32};
    tbl[1] = '{v:1, t:1, d:64'hA1, r:0, lv:0, ld:64'h0,  cr:32};
    tbl[2] = '{v:1, t:1, d:64'hA2, r:0, lv:0, ld:64'h0,  cr:32};
    tbl[3] = '{v:1, t:1, d:64'hA3, r:0, lv:0, ld:64'h0,  cr:32};
    tbl[4] = '{v:1, t:1, d:64'hD0, r:1, lv:0, ld:64'h0,  cr:32};
    tbl[5] = '{v:0, t:1, d:64'hEE, r:1, lv:1, ld:64'hD0, cr:31};
    tbl[6] = '{v:1, t:1, d:64'hD1, r:1, lv:0, ld:64'hD0, cr:31};
    tbl[7] = '{v:1, t:1, d:64'hD2, r:1, lv:1, ld:64'hD1, cr:30};
    tbl[8] = '{v:0, t:1, d:64'h55, r:1, lv:1, ld:64'hD2, cr:29};
    tbl[9] = '{v:0, t:1, d:64'h66, r:1, lv:0, ld:64'hD2, cr:29};

    #1;
    chk("reset_ready", {63'd0, ready}, 64'd0);
    chk("reset_lv", {63'd0, lv}, 64'd0);
    chk("reset_credits", 64'(credits), 64'd32);
    chk("reset_err", {63'd0, err}, 64'd0);
    chk("reset_ldata", ldata, 64'd0);

    // Init timing, token toggled during init, basic transfers and data hold.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("vec%0d_ready", i), {63'd0, ready}, {63'd0, tbl[i].r});
      chk($sformatf("vec%0d_lv", i), {63'd0, lv}, {63'd0, tbl[i].lv});
      chk($sformatf("vec%0d_ldata", i), ldata, tbl[i].ld);
      chk($sformatf("vec%0d_credits", i), 64'(credits), 64'(tbl[i].cr));
      chk($sformatf("vec%0d_err", i), {63'd0, err}, 64'd0);
      valid = tbl[i].v;
      tok   = tbl[i].t;
      data  = tbl[i].d;
      tick();
    end

    // Drain: constant valid, no token, exactly 32 pulses from cycle 5.
    valid = 1'b0;
    do_reset();
    valid = 1'b1;
    cnt   = 0;
    first = -1;
    for (int i = 0; i < 60; i++) begin
      if (lv) begin
        cnt++;
        if (first < 0) first = i;
      end
      data = 64'(i);
      tick();
    end
    chk("drain_pulses", 64'(cnt), 64'd32);
    chk("drain_first_cycle", 64'(first), 64'd5);
    chk("drain_ready", {63'd0, ready}, 64'd0);
    chk("drain_credits", 64'(credits), 64'd0);

    // Refill from zero: visible three cycles after the toggle, never early.
    valid = 1'b0;
    tok   = ~tok;
    tick();
    chk("refill_c1_credits", 64'(credits), 64'd0);
    tick();
    chk("refill_c2_credits", 64'(credits), 64'd0);
    chk("refill_c2_ready", {63'd0, ready}, 64'd0);
    tick();
    chk("refill_c3_credits", 64'(credits), 64'd4);
    chk("refill_c3_ready", {63'd0, ready}, 64'd1);
    valid = 1'b1;
    cnt   = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (lv) cnt++;
    end
    chk("refill_pulses", 64'(cnt), 64'd4);
    chk("refill_end_credits", 64'(credits), 64'd0);
    chk("refill_end_ready", {63'd0, ready}, 64'd0);

    // Transfer and token edge in the same cycle: 10 + 4 - 1.
    valid = 1'b0;
    do_reset();
    repeat (4) tick();
    chk("simul_ready", {63'd0, ready}, 64'd1);
    valid = 1'b1;
    repeat (22) tick();
    valid = 1'b0;
    chk("simul_pre_credits", 64'(credits), 64'd10);
    tok = ~tok;
    tick();
    tick();
    valid = 1'b1;
    tick();
    valid = 1'b0;
    chk("simul_credits", 64'(credits), 64'd13);
    chk("simul_lv", {63'd0, lv}, 64'd1);
    chk("simul_err", {63'd0, err}, 64'd0);

    // Overflow: 30 + 4 saturates at 32 and locks into error.
    do_reset();
    repeat (4) tick();
    valid = 1'b1;
    repeat (2) tick();
    valid = 1'b0;
    chk("ovf_pre_credits", 64'(credits), 64'd30);
    tok = ~tok;
    repeat (3) tick();
    chk("ovf_credits", 64'(credits), 64'd32);
    chk("ovf_err", {63'd0, err}, 64'd1);
    chk("ovf_ready", {63'd0, ready}, 64'd0);
    valid = 1'b1;
    tok   = ~tok;
    cnt   = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (lv || ready) cnt++;
    end
    chk("ovf_locked_activity", 64'(cnt), 64'd0);
    chk("ovf_locked_err", {63'd0, err}, 64'd1);
    chk("ovf_locked_credits", 64'(credits), 64'd32);

    // Reset asserted while a word is on the link.
    valid = 1'b0;
    do_reset();
    repeat (4) tick();
    valid = 1'b1;
    data  = 64'hFEED;
    tick();
    chk("midrst_pre_lv", {63'd0, lv}, 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_lv", {63'd0, lv}, 64'd0);
    chk("midrst_credits", 64'(credits), 64'd32);
    chk("midrst_ready", {63'd0, ready}, 64'd0);
    chk("midrst_ldata", ldata, 64'd0);
    chk("midrst_err", {63'd0, err}, 64'd0);
    tick();
    rst   = 1'b0;
    first = -1;
    for (int i = 0; i < 20; i++) begin
      if (lv && first < 0) first = i;
      tick();
    end
    chk("midrst_resume_cycle", 64'(first), 64'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
